// File: rtl/pipeline_hazard_ctrl.sv
// Stall/bubble sequencer for the 5-stage RV32I pipeline registers.
// Handles post-reset fill, load-use bubbles, branch flushes and data-memory waits with timeout.
module pipeline_hazard_ctrl #(
    parameter int INIT_CYCLES = 4,
    parameter int MAX_WAIT    = 16,
    parameter int CNT_W       = 16
) (
    input  logic             Clk,
    input  logic             Clear,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_mem_read,
    input  logic             ex_branch_taken,
    input  logic             mem_req,
    input  logic             mem_ack,
    output logic             stall_pc,
    output logic             stall_ifid,
    output logic             stall_idex,
    output logic             stall_exmem,
    output logic             stall_memwb,
    output logic             clear_ifid,
    output logic             clear_idex,
    output logic             mem_err,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    // state | meaning
    // INIT  | pipeline fill after reset: PC held, IF/ID and ID/EX bubbled
    // RUN   | normal issue; memory wait, branch flush, load-use in priority order
    // MEM_W | data memory outstanding: whole pipeline frozen
    // ERR   | memory timeout: frozen until Clear
    typedef enum logic [1:0] {
        S_INIT     = 2'd0,
        S_RUN      = 2'd1,
        S_MEM_WAIT = 2'd2,
        S_ERR      = 2'd3
    } state_t;

    localparam logic [3:0]       INIT_LOAD = 4'(INIT_CYCLES - 1);
    localparam logic [7:0]       WAIT_LAST = 8'(MAX_WAIT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    state_t           state_q, state_d;
    logic [3:0]       init_q, init_d;
    logic [7:0]       wait_q, wait_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic             load_use;
    logic             flush_inc;
    logic             stall_inc;

    assign load_use = ex_mem_read && (ex_rd != 5'd0) &&
                      ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                       (id_use_rs2 && (id_rs2 == ex_rd)));

    always_comb begin
        state_d     = state_q;
        init_d      = init_q;
        wait_d      = wait_q;
        err_d       = err_q;
        stall_pc    = 1'b0;
        stall_ifid  = 1'b0;
        stall_idex  = 1'b0;
        stall_exmem = 1'b0;
        stall_memwb = 1'b0;
        clear_ifid  = 1'b0;
        clear_idex  = 1'b0;
        flush_inc   = 1'b0;
        case (state_q)
            S_INIT: begin
                stall_pc   = 1'b1;
                clear_ifid = 1'b1;
                clear_idex = 1'b1;
                if (init_q == 4'd0) begin
                    state_d = S_RUN;
                end else begin
                    init_d = init_q - 4'd1;
                end
            end
            S_RUN: begin
                if (mem_req && !mem_ack) begin
                    {stall_pc, stall_ifid, stall_idex, stall_exmem, stall_memwb} = 5'b11111;
                    state_d = S_MEM_WAIT;
                    wait_d  = 8'd1;
                end else if (ex_branch_taken) begin
                    // ID holds a wrong-path instruction, so its load-use match is moot
                    clear_ifid = 1'b1;
                    clear_idex = 1'b1;
                    flush_inc  = 1'b1;
                end else if (load_use) begin
                    stall_pc   = 1'b1;
                    stall_ifid = 1'b1;
                    clear_idex = 1'b1;
                end
            end
            S_MEM_WAIT: begin
                if (mem_ack) begin
                    state_d = S_RUN;
                    wait_d  = 8'd0;
                end else begin
                    {stall_pc, stall_ifid, stall_idex, stall_exmem, stall_memwb} = 5'b11111;
                    wait_d = wait_q + 8'd1;
                    if (wait_q >= WAIT_LAST) begin
                        state_d = S_ERR;
                        err_d   = 1'b1;
                    end
                end
            end
            default: begin
                {stall_pc, stall_ifid, stall_idex, stall_exmem, stall_memwb} = 5'b11111;
                err_d = 1'b1;
            end
        endcase
    end

    assign stall_inc   = stall_pc && ((state_q == S_RUN) || (state_q == S_MEM_WAIT));
    assign stall_cnt_d = (stall_inc && (stall_cnt_q != CNT_MAX)) ? stall_cnt_q + 1'b1 : stall_cnt_q;
    assign flush_cnt_d = (flush_inc && (flush_cnt_q != CNT_MAX)) ? flush_cnt_q + 1'b1 : flush_cnt_q;

    always_ff @(posedge Clk) begin
        if (Clear) begin
            state_q     <= S_INIT;
            init_q      <= INIT_LOAD;
            wait_q      <= 8'd0;
            err_q       <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            init_q      <= init_d;
            wait_q      <= wait_d;
            err_q       <= err_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign mem_err     = err_q;
    assign state       = state_q;
    assign stall_count = stall_cnt_q;
    assign flush_count = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: each cycle's expected control vector is queued
// when the stimulus is applied and compared once the combinational outputs settle.
module tb_pipeline_hazard_ctrl;

    localparam int INIT_CYCLES = 4;
    localparam int MAX_WAIT    = 16;
    localparam int CNT_W       = 4;
    localparam int CNT_MAX     = (1 << CNT_W) - 1;

    // {state[1:0], mem_err, stall pc/ifid/idex/exmem/memwb, clear ifid/idex}
    localparam logic [9:0] C_INIT  = {2'd0, 1'b0, 5'b10000, 2'b11};
    localparam logic [9:0] C_IDLE  = {2'd1, 1'b0, 5'b00000, 2'b00};
    localparam logic [9:0] C_LU    = {2'd1, 1'b0, 5'b11000, 2'b01};
    localparam logic [9:0] C_BR    = {2'd1, 1'b0, 5'b00000, 2'b11};
    localparam logic [9:0] C_RUNMW = {2'd1, 1'b0, 5'b11111, 2'b00};
    localparam logic [9:0] C_MW    = {2'd2, 1'b0, 5'b11111, 2'b00};
    localparam logic [9:0] C_MWREL = {2'd2, 1'b0, 5'b00000, 2'b00};
    localparam logic [9:0] C_ERR   = {2'd3, 1'b1, 5'b11111, 2'b00};

    typedef struct packed {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u1;
        logic       u2;
        logic [4:0] rd;
        logic       mr;
        logic       bt;
        logic       req;
        logic       ack;
    } stim_t;

    typedef struct {
        string      tag;
        logic [9:0] v;
    } exp_t;

    logic             Clk = 1'b0;
    logic             Clear;
    logic [4:0]       id_rs1, id_rs2, ex_rd;
    logic             id_use_rs1, id_use_rs2, ex_mem_read, ex_branch_taken, mem_req, mem_ack;
    logic             stall_pc, stall_ifid, stall_idex, stall_exmem, stall_memwb;
    logic             clear_ifid, clear_idex, mem_err;
    logic [1:0]       state;
    logic [CNT_W-1:0] stall_count, flush_count;
    logic [9:0]       obs;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   exp_stall = 0;
    int   exp_flush = 0;

    pipeline_hazard_ctrl #(
        .INIT_CYCLES(INIT_CYCLES),
        .MAX_WAIT   (MAX_WAIT),
        .CNT_W      (CNT_W)
    ) dut (
        .Clk            (Clk),
        .Clear          (Clear),
        .id_rs1         (id_rs1),
        .id_rs2         (id_rs2),
        .id_use_rs1     (id_use_rs1),
        .id_use_rs2     (id_use_rs2),
        .ex_rd          (ex_rd),
        .ex_mem_read    (ex_mem_read),
        .ex_branch_taken(ex_branch_taken),
        .mem_req        (mem_req),
        .mem_ack        (mem_ack),
        .stall_pc       (stall_pc),
        .stall_ifid     (stall_ifid),
        .stall_idex     (stall_idex),
        .stall_exmem    (stall_exmem),
        .stall_memwb    (stall_memwb),
        .clear_ifid     (clear_ifid),
        .clear_idex     (clear_idex),
        .mem_err        (mem_err),
        .state          (state),
        .stall_count    (stall_count),
        .flush_count    (flush_count)
    );

    assign obs = {state, mem_err, stall_pc, stall_ifid, stall_idex, stall_exmem, stall_memwb,
                  clear_ifid, clear_idex};

    always #5 Clk = ~Clk;

    function automatic stim_t mk(input logic [4:0] rs1, input logic [4:0] rs2, input logic u1,
                                 input logic u2, input logic [4:0] rd, input logic mr,
                                 input logic bt, input logic req, input logic ack);
        stim_t s;
        s.rs1 = rs1; s.rs2 = rs2; s.u1 = u1; s.u2 = u2; s.rd = rd;
        s.mr = mr; s.bt = bt; s.req = req; s.ack = ack;
        return s;
    endfunction

    task automatic drive(input stim_t s);
        id_rs1          = s.rs1;
        id_rs2          = s.rs2;
        id_use_rs1      = s.u1;
        id_use_rs2      = s.u2;
        ex_rd           = s.rd;
        ex_mem_read     = s.mr;
        ex_branch_taken = s.bt;
        mem_req         = s.req;
        mem_ack         = s.ack;
    endtask

    // Reference statistics: derived from the expected vector the cycle is about to commit.
    task automatic model_update(input logic [9:0] v);
        if ((v[9:8] == 2'd1 || v[9:8] == 2'd2) && v[6] && exp_stall < CNT_MAX) exp_stall++;
        if (v[9:8] == 2'd1 && v[1] && !v[6] && exp_flush < CNT_MAX) exp_flush++;
    endtask

    task automatic do_reset();
        @(negedge Clk);
        Clear = 1'b1;
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        Clear = 1'b0;
        repeat (INIT_CYCLES) @(posedge Clk);
        exp_stall = 0;
        exp_flush = 0;
    endtask

    task automatic test_reset();
        exp_t e;
        @(negedge Clk);
        Clear = 1'b1;
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
        repeat (2) @(posedge Clk);
        exp_stall = 0;
        exp_flush = 0;
        for (int i = 0; i <= INIT_CYCLES; i++) begin
            @(negedge Clk);
            Clear = 1'b0;
            sb_q.push_back('{$sformatf("reset_cyc%0d", i), (i < INIT_CYCLES) ? C_INIT : C_IDLE});
            #1;
            e = sb_q.pop_front();
            n_checks++;
            if (obs !== e.v) begin
                n_fail++;
                $display("FAIL %s: got %b expected %b", e.tag, obs, e.v);
            end
            model_update(e.v);
        end
        n_checks++;
        if (stall_count !== CNT_W'(0) || flush_count !== CNT_W'(0)) begin
            n_fail++;
            $display("FAIL reset_counters: got stall=%0d flush=%0d expected 0/0", stall_count, flush_count);
        end
    endtask

    task automatic test_load_use();
        stim_t      s[7];
        logic [9:0] x[7];
        exp_t       e;
        do_reset();
        s[0] = mk(0, 5, 0, 1, 5, 1, 0, 0, 0);  x[0] = C_LU;
        s[1] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);  x[1] = C_IDLE;
        s[2] = mk(0, 0, 0, 1, 0, 1, 0, 0, 0);  x[2] = C_IDLE;
        s[3] = mk(7, 3, 1, 0, 7, 1, 0, 0, 0);  x[3] = C_LU;
        s[4] = mk(1, 5, 1, 0, 5, 1, 0, 0, 0);  x[4] = C_IDLE;
        s[5] = mk(5, 5, 1, 1, 5, 0, 0, 0, 0);  x[5] = C_IDLE;
        s[6] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);  x[6] = C_IDLE;
        for (int i = 0; i < 7; i++) begin
            @(negedge Clk);
            drive(s[i]);
            sb_q.push_back('{$sformatf("load_use_%0d", i), x[i]});
            #1;
            e = sb_q.pop_front();
            n_checks++;
            if (obs !== e.v) begin
                n_fail++;
                $display("FAIL %s: got %b expected %b", e.tag, obs, e.v);
            end
            model_update(e.v);
        end
        @(negedge Clk);
        n_checks++;
        if (stall_count !== CNT_W'(exp_stall)) begin
            n_fail++;
            $display("FAIL load_use_stall_count: got %0d expected %0d", stall_count, exp_stall);
        end
    endtask

    task automatic test_branch();
        stim_t      s[2];
        logic [9:0] x[2];
        exp_t       e;
        s[0] = mk(0, 5, 0, 1, 5, 1, 1, 0, 0);  x[0] = C_BR;
        s[1] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);  x[1] = C_IDLE;
        for (int i = 0; i < 2; i++) begin
            @(negedge Clk);
            drive(s[i]);
            sb_q.push_back('{$sformatf("branch_%0d", i), x[i]});
            #1;
            e = sb_q.pop_front();
            n_checks++;
            if (obs !== e.v) begin
                n_fail++;
                $display("FAIL %s: got %b expected %b", e.tag, obs, e.v);
            end
            model_update(e.v);
        end
        @(negedge Clk);
        n_checks++;
        if (flush_count !== CNT_W'(exp_flush) || stall_count !== CNT_W'(exp_stall)) begin
            n_fail++;
            $display("FAIL branch_counters: got stall=%0d flush=%0d expected %0d/%0d",
                     stall_count, flush_count, exp_stall, exp_flush);
        end
    endtask

    task automatic test_mem_wait();
        stim_t      s[8];
        logic [9:0] x[8];
        exp_t       e;
        do_reset();
        s[0] = mk(0, 0, 0, 0, 0, 0, 0, 1, 0);  x[0] = C_RUNMW;
        s[1] = mk(0, 5, 0, 1, 5, 1, 1, 1, 0);  x[1] = C_MW;
        s[2] = mk(0, 0, 0, 0, 0, 0, 0, 1, 0);  x[2] = C_MW;
        s[3] = mk(0, 0, 0, 0, 0, 0, 0, 1, 1);  x[3] = C_MWREL;
        s[4] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);  x[4] = C_IDLE;
        s[5] = mk(0, 0, 0, 0, 0, 0, 0, 1, 1);  x[5] = C_IDLE;
        s[6] = mk(0, 0, 0, 0, 0, 0, 1, 1, 1);  x[6] = C_BR;
        s[7] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);  x[7] = C_IDLE;
        for (int i = 0; i < 8; i++) begin
            @(negedge Clk);
            drive(s[i]);
            sb_q.push_back('{$sformatf("mem_wait_%0d", i), x[i]});
            #1;
            e = sb_q.pop_front();
            n_checks++;
            if (obs !== e.v) begin
                n_fail++;
                $display("FAIL %s: got %b expected %b", e.tag, obs, e.v);
            end
            model_update(e.v);
        end
        @(negedge Clk);
        n_checks++;
        if (stall_count !== CNT_W'(exp_stall) || flush_count !== CNT_W'(exp_flush)) begin
            n_fail++;
            $display("FAIL mem_wait_counters: got stall=%0d flush=%0d expected %0d/%0d",
                     stall_count, flush_count, exp_stall, exp_flush);
        end
    endtask

    task automatic test_timeout();
        exp_t  e;
        stim_t s;
        logic [9:0] x;
        do_reset();
        for (int i = 0; i < MAX_WAIT + 3; i++) begin
            @(negedge Clk);
            s = mk(0, 0, 0, 0, 0, 0, 0, 1, (i == MAX_WAIT + 1) ? 1'b1 : 1'b0);
            if (i == 0) x = C_RUNMW;
            else if (i < MAX_WAIT) x = C_MW;
            else x = C_ERR;
            drive(s);
            sb_q.push_back('{$sformatf("timeout_%0d", i), x});
            #1;
            e = sb_q.pop_front();
            n_checks++;
            if (obs !== e.v) begin
                n_fail++;
                $display("FAIL %s: got %b expected %b", e.tag, obs, e.v);
            end
            model_update(e.v);
        end
        @(negedge Clk);
        n_checks++;
        if (stall_count !== CNT_W'(exp_stall)) begin
            n_fail++;
            $display("FAIL timeout_stall_sat: got %0d expected %0d", stall_count, exp_stall);
        end
        Clear = 1'b1;
        @(posedge Clk);
        @(negedge Clk);
        sb_q.push_back('{"timeout_clear", C_INIT});
        #1;
        e = sb_q.pop_front();
        n_checks++;
        if (obs !== e.v || stall_count !== CNT_W'(0)) begin
            n_fail++;
            $display("FAIL %s: got %b cnt=%0d expected %b cnt=0", e.tag, obs, stall_count, e.v);
        end
        Clear = 1'b0;
    endtask

    task automatic test_saturation();
        exp_t e;
        do_reset();
        for (int i = 0; i < 21; i++) begin
            @(negedge Clk);
            drive(mk(0, 0, 0, 0, 0, 0, (i < 20) ? 1'b1 : 1'b0, 0, 0));
            sb_q.push_back('{$sformatf("sat_%0d", i), (i < 20) ? C_BR : C_IDLE});
            #1;
            e = sb_q.pop_front();
            n_checks++;
            if (obs !== e.v) begin
                n_fail++;
                $display("FAIL %s: got %b expected %b", e.tag, obs, e.v);
            end
            model_update(e.v);
        end
        @(negedge Clk);
        n_checks++;
        if (flush_count !== CNT_W'(exp_flush) || exp_flush != CNT_MAX) begin
            n_fail++;
            $display("FAIL flush_saturation: got %0d expected %0d", flush_count, CNT_MAX);
        end
    endtask

    initial begin
        Clear = 1'b1;
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
        test_reset();
        test_load_use();
        test_branch();
        test_mem_wait();
        test_timeout();
        test_saturation();
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
